// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, drives the
// combinational instruction memory and loads the IF/ID pipeline register.
module if_fetch_stage #(
  parameter int              PC_W        = 32,
  parameter int              IMEM_ADDR_W = 7,
  parameter int              IMEM_WORDS  = 30,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   br_taken,
  input  logic [PC_W-1:0]        br_target,
  input  logic                   jmp,
  input  logic [PC_W-1:0]        jmp_target,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_data,
  output logic [PC_W-1:0]        pc,
  output logic [31:0]            ifid_instr,
  output logic [PC_W-1:0]        ifid_pc4,
  output logic                   ifid_valid,
  output logic                   fetch_done,
  output logic [CNT_W-1:0]       fetch_count
);

  localparam logic [PC_W-1:0] PC_END = PC_W'(IMEM_WORDS * 4);

  logic            redirect;
  logic [PC_W-1:0] target_sel;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_plus4;
  logic            in_range;

  assign redirect   = br_taken | jmp;
  // Branch outranks jump when ID raises both in the same cycle.
  assign target_sel = br_taken ? br_target : jmp_target;
  assign target     = target_sel & ~PC_W'(3);
  assign pc_plus4   = pc + PC_W'(4);
  // Compare the full PC so a wrapped or high address never aliases into range.
  assign in_range   = (pc < PC_END);
  assign imem_addr  = pc[IMEM_ADDR_W-1:0];

  // NOTE: every register here uses <= so all updates see the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      ifid_instr  <= '0;
      ifid_pc4    <= '0;
      ifid_valid  <= 1'b0;
      fetch_done  <= 1'b0;
      fetch_count <= '0;
    end else begin
      // Sticky end-of-program flag; only reset clears it.
      if (!in_range && !redirect) fetch_done <= 1'b1;

      if (redirect) begin
        // Squash the single wrong-path slot, regardless of stall.
        pc         <= target;
        ifid_instr <= '0;
        ifid_pc4   <= '0;
        ifid_valid <= 1'b0;
      end else if (!stall) begin
        pc         <= pc_plus4;
        ifid_pc4   <= pc_plus4;
        ifid_instr <= in_range ? imem_data : 32'h0;
        ifid_valid <= in_range;
        if (in_range && (fetch_count != {CNT_W{1'b1}}))
          fetch_count <= fetch_count + CNT_W'(1);
      end
    end
  end

endmodule
